dds_hop_scheduler: RTL and testbench

//  Table-driven frequency-hop sequencer for the hop DDS channel (ad9914_ctrl instance 2).

---
 rtl/dds_pkg.sv | 13 +
 rtl/hop_table_ram.sv | 26 ++
 rtl/dds_hop_scheduler.sv | 125 ++++++++++++
 tb/tb_dds_hop_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the hop DDS scheduler: FSM state encoding and FTW width.
package dds_pkg;

  localparam int FTW_W = 32;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_ADV       = 3'd5;

endpackage

// File: rtl/hop_table_ram.sv
// Hop FTW table: synchronous write, registered read. A same-clock write to the
// address being read returns the previous contents.
module hop_table_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dds_hop_scheduler.sv
// Table-driven frequency-hop sequencer: each accepted hop trigger fetches the next
// FTW, issues one update to the DDS controller and tracks its busy handshake.
module dds_hop_scheduler
  import dds_pkg::*;
#(
  parameter int TBL_ADDR_W  = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int FTW_W       = dds_pkg::FTW_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_tbl_wr_en,
  input  logic [TBL_ADDR_W-1:0] i_tbl_wr_addr,
  input  logic [FTW_W-1:0]      i_tbl_wr_data,
  input  logic [TBL_ADDR_W:0]   i_tbl_len,
  input  logic                  i_frame_start,
  input  logic                  i_hop_trig,
  input  logic                  i_dds_busy,
  output logic                  o_dds_update,
  output logic [FTW_W-1:0]      o_dds_ftw_l,
  output logic [FTW_W-1:0]      o_dds_ftw_u,
  output logic [TBL_ADDR_W-1:0] o_hop_idx,
  output logic                  o_active,
  output logic                  o_overrun,
  output logic                  o_timeout_err
);

  localparam int IW    = TBL_ADDR_W + 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [IW-1:0]    DEPTH    = IW'(2**TBL_ADDR_W);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  logic [2:0]            r_state;
  logic [IW-1:0]         r_nidx;
  logic [IW-1:0]         r_len;
  logic [TMR_W-1:0]      r_timer;
  logic [FTW_W-1:0]      r_ftw;
  logic [TBL_ADDR_W-1:0] r_hop_idx;
  logic                  r_update;
  logic                  r_overrun;

  logic                  w_accept;
  logic                  w_timeout;
  logic [TBL_ADDR_W-1:0] w_rd_addr;
  logic [FTW_W-1:0]      w_rd_data;
  logic [IW-1:0]         w_nidx_inc;
  logic [IW-1:0]         w_len_eff;

  assign w_accept   = (r_state == S_IDLE) && i_enable && i_hop_trig;
  assign w_timeout  = (r_state == S_WAIT_ACK) && !i_dds_busy && (r_timer == TMR_LAST);
  // A frame start in the trigger clock rewinds first, so the hop reads entry 0.
  assign w_rd_addr  = i_frame_start ? '0 : r_nidx[TBL_ADDR_W-1:0];
  assign w_nidx_inc = r_nidx + IW'(1);
  // Zero length means one entry; oversize lengths clamp to the table depth.
  assign w_len_eff  = (i_tbl_len == '0) ? IW'(1) :
                      (i_tbl_len > DEPTH) ? DEPTH : i_tbl_len;

  hop_table_ram #(
    .ADDR_W (TBL_ADDR_W),
    .DATA_W (FTW_W)
  ) u_tbl (
    .i_clk     (i_clk),
    .i_wr_en   (i_tbl_wr_en),
    .i_wr_addr (i_tbl_wr_addr),
    .i_wr_data (i_tbl_wr_data),
    .i_rd_en   (w_accept),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_nidx    <= '0;
      r_len     <= IW'(1);
      r_timer   <= '0;
      r_ftw     <= '0;
      r_hop_idx <= '0;
      r_update  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_update  <= 1'b0;
      r_overrun <= i_hop_trig && i_enable && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: if (w_accept) r_state <= S_FETCH;
        S_FETCH: begin
          r_ftw     <= w_rd_data;
          r_hop_idx <= r_nidx[TBL_ADDR_W-1:0];
          r_update  <= 1'b1;
          r_state   <= S_REQ;
        end
        S_REQ: begin
          r_timer <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i_dds_busy)                r_state <= S_WAIT_DONE;
          else if (r_timer == TMR_LAST)  r_state <= S_ADV;
          else                           r_timer <= r_timer + TMR_W'(1);
        end
        S_WAIT_DONE: if (!i_dds_busy) r_state <= S_ADV;
        S_ADV: begin
          r_nidx  <= (w_nidx_inc >= r_len) ? '0 : w_nidx_inc;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed after the FSM so a rewind overrides the ADV increment.
      if (i_frame_start) begin
        r_nidx <= '0;
        r_len  <= w_len_eff;
      end
    end
  end

  assign o_dds_update  = r_update;
  assign o_dds_ftw_l   = r_ftw;
  assign o_dds_ftw_u   = r_ftw;
  assign o_hop_idx     = r_hop_idx;
  assign o_active      = (r_state != S_IDLE);
  assign o_overrun     = r_overrun;
  assign o_timeout_err = w_timeout;

endmodule

// File: tb/tb_dds_hop_scheduler.sv
// Scoreboard bench for dds_hop_scheduler: stimulus queues expected events, a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_dds_hop_scheduler;

  localparam int AW = 4;
  localparam int FW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_enable = 1'b1;
  logic          i_tbl_wr_en = 1'b0;
  logic [AW-1:0] i_tbl_wr_addr = '0;
  logic [FW-1:0] i_tbl_wr_data = '0;
  logic [AW:0]   i_tbl_len = 5'd1;
  logic          i_frame_start = 1'b0;
  logic          i_hop_trig = 1'b0;
  logic          i_dds_busy = 1'b0;
  logic          o_dds_update, o_active, o_overrun, o_timeout_err;
  logic [FW-1:0] o_dds_ftw_l, o_dds_ftw_u;
  logic [AW-1:0] o_hop_idx;

  dds_hop_scheduler #(.TBL_ADDR_W(AW), .ACK_TIMEOUT(64), .FTW_W(FW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_tbl_wr_en(i_tbl_wr_en), .i_tbl_wr_addr(i_tbl_wr_addr), .i_tbl_wr_data(i_tbl_wr_data),
    .i_tbl_len(i_tbl_len), .i_frame_start(i_frame_start), .i_hop_trig(i_hop_trig),
    .i_dds_busy(i_dds_busy), .o_dds_update(o_dds_update), .o_dds_ftw_l(o_dds_ftw_l),
    .o_dds_ftw_u(o_dds_ftw_u), .o_hop_idx(o_hop_idx), .o_active(o_active),
    .o_overrun(o_overrun), .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  typedef struct { logic [FW-1:0] ftw; logic [AW-1:0] idx; int cyc; } upd_t;
  typedef struct { int cyc; logic [71:0] v; } snap_t;

  upd_t  upd_q[$];
  int    ovr_q[$];
  int    to_q[$];
  snap_t snap_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    done = 1'b0;
  bit    bm_on = 1'b1;
  int    bm_cnt = 0;
  upd_t  m_e;
  snap_t m_s;
  int    m_c;

  logic [71:0] w_snap;
  assign w_snap = {o_active, o_dds_update, o_dds_ftw_l, o_dds_ftw_u, o_hop_idx, o_overrun, o_timeout_err};

  // Controller busy model: busy high for 3 clocks starting the clock after an update.
  always @(negedge i_clk) begin
    if (bm_cnt > 0) begin
      i_dds_busy = 1'b1;
      bm_cnt--;
    end else begin
      i_dds_busy = 1'b0;
    end
    if (o_dds_update && bm_on) bm_cnt = 3;
  end

  always @(negedge i_clk) begin
    if (o_dds_update) begin
      n_cmp++;
      if (upd_q.size() == 0) begin
        n_err++;
        $display("FAIL update: unexpected at cyc %0d ftw=%h idx=%0d", cyc, o_dds_ftw_l, o_hop_idx);
      end else begin
        m_e = upd_q.pop_front();
        if (o_dds_ftw_l !== m_e.ftw || o_dds_ftw_u !== m_e.ftw || o_hop_idx !== m_e.idx || cyc != m_e.cyc) begin
          n_err++;
          $display("FAIL update: got ftw_l=%h ftw_u=%h idx=%0d cyc=%0d, want ftw=%h idx=%0d cyc=%0d",
                   o_dds_ftw_l, o_dds_ftw_u, o_hop_idx, cyc, m_e.ftw, m_e.idx, m_e.cyc);
        end
      end
    end
    if (o_overrun) begin
      n_cmp++;
      if (ovr_q.size() == 0) begin
        n_err++;
        $display("FAIL overrun: unexpected at cyc %0d", cyc);
      end else begin
        m_c = ovr_q.pop_front();
        if (cyc != m_c) begin
          n_err++;
          $display("FAIL overrun: got cyc %0d, want cyc %0d", cyc, m_c);
        end
      end
    end
    if (o_timeout_err) begin
      n_cmp++;
      if (to_q.size() == 0) begin
        n_err++;
        $display("FAIL timeout: unexpected at cyc %0d", cyc);
      end else begin
        m_c = to_q.pop_front();
        if (cyc != m_c) begin
          n_err++;
          $display("FAIL timeout: got cyc %0d, want cyc %0d", cyc, m_c);
        end
      end
    end
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      m_s = snap_q.pop_front();
      n_cmp++;
      if (w_snap !== m_s.v) begin
        n_err++;
        $display("FAIL snapshot cyc %0d: got act=%b upd=%b ftw=%h/%h idx=%0d ovr=%b to=%b, want all 0",
                 cyc, o_active, o_dds_update, o_dds_ftw_l, o_dds_ftw_u, o_hop_idx, o_overrun, o_timeout_err);
      end
    end
    if (done || cyc > 20000) begin
      if (cyc > 20000) begin
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: cycle budget expired at cyc %0d", cyc);
      end
      n_cmp++;
      if (upd_q.size() != 0 || ovr_q.size() != 0 || to_q.size() != 0) begin
        n_err++;
        $display("FAIL missing events: upd=%0d ovr=%0d to=%0d still pending, want 0",
                 upd_q.size(), ovr_q.size(), to_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic hop(input logic [FW-1:0] f, input logic [AW-1:0] ix, input int gap, input bit fs = 1'b0);
    tick();
    i_hop_trig = 1'b1;
    i_frame_start = fs;
    upd_q.push_back('{f, ix, cyc + 2});
    tick();
    i_hop_trig = 1'b0;
    i_frame_start = 1'b0;
    repeat (gap) @(posedge i_clk);
  endtask

  task automatic trig_only(input bit exp_ovr);
    tick();
    i_hop_trig = 1'b1;
    if (exp_ovr) ovr_q.push_back(cyc + 1);
    tick();
    i_hop_trig = 1'b0;
  endtask

  task automatic frame(input logic [AW:0] len);
    i_tbl_len = len;
    tick();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  task automatic chk_zero();
    tick();
    snap_q.push_back('{cyc, 72'b0});
  endtask

  initial begin
    repeat (3) tick();
    snap_q.push_back('{cyc, 72'b0});
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      i_tbl_wr_en = 1'b1;
      i_tbl_wr_addr = AW'(i);
      i_tbl_wr_data = FW'((i + 1) * 256);
    end
    tick();
    i_tbl_wr_en = 1'b0;

    // Basic sequence over a 3-entry table, wrapping once.
    frame(5'd3);
    hop(32'h100, 4'd0, 8);
    hop(32'h200, 4'd1, 8);
    hop(32'h300, 4'd2, 8);
    hop(32'h100, 4'd0, 8);

    // Trigger while busy: overrun, no update, index unaffected.
    hop(32'h200, 4'd1, 2);
    trig_only(1'b1);
    repeat (8) tick();
    hop(32'h300, 4'd2, 8);

    // Busy never rises: timeout at update+64, index still advances.
    bm_on = 1'b0;
    hop(32'h100, 4'd0, 0);
    to_q.push_back(cyc - 1 + 2 + 64);
    repeat (70) tick();
    bm_on = 1'b1;
    hop(32'h200, 4'd1, 8);

    // Rewind mid-table, rewind coincident with ADV, rewind with trigger.
    frame(5'd3);
    hop(32'h100, 4'd0, 8);
    hop(32'h200, 4'd1, 5);
    frame(5'd3);
    hop(32'h100, 4'd0, 8);
    hop(32'h100, 4'd0, 8, 1'b1);

    // Zero length behaves as one entry; full-depth table walks all entries.
    frame(5'd0);
    for (int i = 0; i < 3; i++) hop(32'h100, 4'd0, 8);
    frame(5'd16);
    for (int i = 0; i < 17; i++) hop(FW'(((i % 16) + 1) * 256), AW'(i % 16), 8);

    // Reset while waiting for busy to fall.
    hop(32'h200, 4'd1, 2);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    snap_q.push_back('{cyc, 72'b0});

    // Disabled: triggers ignored silently.
    i_enable = 1'b0;
    trig_only(1'b0);
    chk_zero();
    trig_only(1'b0);
    for (int i = 0; i < 4; i++) chk_zero();
    i_enable = 1'b1;
    repeat (4) tick();

    // Write to the entry being fetched returns the old data.
    tick();
    i_hop_trig = 1'b1;
    i_tbl_wr_en = 1'b1;
    i_tbl_wr_addr = '0;
    i_tbl_wr_data = 32'hABC;
    upd_q.push_back('{32'h100, 4'd0, cyc + 2});
    tick();
    i_hop_trig = 1'b0;
    i_tbl_wr_en = 1'b0;
    repeat (8) tick();
    hop(32'hABC, 4'd0, 8);

    repeat (10) tick();
    done = 1'b1;
  end

endmodule
